sodor5_pipe_checker: RTL and testbench

- Self-checking harness: a 5-stage in-order pipeline (IF/ID/EX/MEM/WB) and a single-cycle golden ISA model run the same RV32I OP-IMM instruction stream.
- Takes one instruction word per clock; no instruction memory, no PC.
- Compares each pipeline retirement against the model's delayed commit record and raises a sticky mismatch flag.
- Used as the DUT for lock-step pipeline-vs-ISA equivalence runs.

---
 rtl/sodor5_pipe_checker.sv | 189 ++++++++++++++++++
 tb/tb_sodor5_pipe_checker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sodor5_pipe_checker.sv
// sodor5_pipe_checker: lock-step equivalence harness for RV32I OP-IMM.
// A 5-stage in-order pipeline (IF/ID/EX/MEM/WB, fully bypassed, no stalls)
// and a single-cycle golden model consume the same instruction stream.
// Each pipeline retirement is compared with the model's commit record,
// delayed 4 cycles to line up with WB.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   instr        instruction sampled every edge (0x00000013 when idle)
//   commit_valid WB stage holds a retiring instruction
//   commit_rd    destination register of the retiring instruction
//   commit_data  result written by the retiring instruction
//   mismatch     sticky pipeline/model disagreement flag
//   commit_count retired instructions since reset (wraps)
module sodor5_pipe_checker #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     instr,
  output logic            commit_valid,
  output logic [4:0]      commit_rd,
  output logic [XLEN-1:0] commit_data,
  output logic            mismatch,
  output logic [31:0]     commit_count
);

  localparam int unsigned AW     = $clog2(NUM_REGS);
  localparam logic [6:0]  OP_IMM = 7'b0010011;

  // Legal OP-IMM encodings; everything else is a bubble.
  function automatic logic f_legal(input logic [31:0] ins);
    logic ok;
    ok = 1'b0;
    if (ins[6:0] == OP_IMM) begin
      case (ins[14:12])
        3'b001:  ok = (ins[31:25] == 7'b0000000);
        3'b101:  ok = (ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000);
        default: ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  // OP-IMM datapath shared by the model and the EX stage.
  function automatic logic [XLEN-1:0] f_alu(input logic [31:0] ins, input logic [XLEN-1:0] a);
    logic [XLEN-1:0] imm;
    logic [4:0]      sh;
    logic [XLEN-1:0] res;
    imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
    sh  = ins[24:20];
    case (ins[14:12])
      3'b000:  res = a + imm;
      3'b010:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(imm))};
      3'b011:  res = {{(XLEN-1){1'b0}}, (a < imm)};
      3'b100:  res = a ^ imm;
      3'b110:  res = a | imm;
      3'b111:  res = a & imm;
      3'b001:  res = a << sh;
      default: res = ins[30] ? XLEN'($signed(a) >>> sh) : (a >> sh);
    endcase
    return res;
  endfunction

  logic [XLEN-1:0] model_rf [NUM_REGS];
  logic [XLEN-1:0] core_rf  [NUM_REGS];

  // Golden model: decode and execute in the sampling cycle.
  logic            w_in_valid;
  logic [4:0]      w_in_rd;
  logic [4:0]      w_in_rs1;
  logic [XLEN-1:0] w_m_a;
  logic [XLEN-1:0] w_m_res;

  assign w_in_valid = f_legal(instr);
  assign w_in_rd    = instr[11:7];
  assign w_in_rs1   = instr[19:15];
  assign w_m_a      = (w_in_rs1 == 5'd0) ? '0 : model_rf[AW'(w_in_rs1)];
  assign w_m_res    = f_alu(instr, w_m_a);

  // Register files are not reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset_n && w_in_valid && (w_in_rd != 5'd0)) model_rf[AW'(w_in_rd)] <= w_m_res;
  end

  logic [3:0]            r_dl_valid;
  logic [3:0][4:0]       r_dl_rd;
  logic [3:0][XLEN-1:0]  r_dl_data;

  // Pipeline registers.
  logic            r_ifid_valid;
  logic [31:0]     r_ifid_instr;
  logic            r_idex_valid;
  logic [31:0]     r_idex_instr;
  logic [XLEN-1:0] r_idex_a;
  logic            r_exmem_valid;
  logic [4:0]      r_exmem_rd;
  logic [XLEN-1:0] r_exmem_data;
  logic            r_memwb_valid;
  logic [4:0]      r_memwb_rd;
  logic [XLEN-1:0] r_memwb_data;
  logic            r_mismatch;
  logic [31:0]     r_count;

  // ID read: bypass the same-edge WB write (3 older).
  logic [4:0]      w_id_rs1;
  logic [XLEN-1:0] w_id_a;
  assign w_id_rs1 = r_ifid_instr[19:15];

  always_comb begin
    w_id_a = '0;
    if (w_id_rs1 != 5'd0) begin
      if (r_memwb_valid && (r_memwb_rd == w_id_rs1)) w_id_a = r_memwb_data;
      else                                           w_id_a = core_rf[AW'(w_id_rs1)];
    end
  end

  // EX operand: EX/MEM (1 older) wins over MEM/WB (2 older); rd=0 never forwarded.
  logic [4:0]      w_ex_rs1;
  logic [XLEN-1:0] w_ex_a;
  logic [XLEN-1:0] w_ex_res;
  assign w_ex_rs1 = r_idex_instr[19:15];

  always_comb begin
    w_ex_a = r_idex_a;
    if (r_exmem_valid && (r_exmem_rd != 5'd0) && (r_exmem_rd == w_ex_rs1))
      w_ex_a = r_exmem_data;
    else if (r_memwb_valid && (r_memwb_rd != 5'd0) && (r_memwb_rd == w_ex_rs1))
      w_ex_a = r_memwb_data;
  end

  assign w_ex_res = f_alu(r_idex_instr, w_ex_a);

  // Commit check against the delay-line head (valid bits compared every cycle).
  logic w_diff;
  assign w_diff = (r_memwb_valid != r_dl_valid[3]) ||
                  (r_memwb_valid && ((r_memwb_rd != r_dl_rd[3]) || (r_memwb_data != r_dl_data[3])));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_valid    <= '0;
      r_dl_rd       <= '0;
      r_dl_data     <= '0;
      r_ifid_valid  <= 1'b0;
      r_ifid_instr  <= '0;
      r_idex_valid  <= 1'b0;
      r_idex_instr  <= '0;
      r_idex_a      <= '0;
      r_exmem_valid <= 1'b0;
      r_exmem_rd    <= '0;
      r_exmem_data  <= '0;
      r_memwb_valid <= 1'b0;
      r_memwb_rd    <= '0;
      r_memwb_data  <= '0;
      r_mismatch    <= 1'b0;
      r_count       <= '0;
    end else begin
      r_dl_valid    <= {r_dl_valid[2:0], w_in_valid};
      r_dl_rd       <= {r_dl_rd[2:0], w_in_rd};
      r_dl_data     <= {r_dl_data[2:0], w_m_res};
      r_ifid_valid  <= w_in_valid;
      r_ifid_instr  <= instr;
      r_idex_valid  <= r_ifid_valid;
      r_idex_instr  <= r_ifid_instr;
      r_idex_a      <= w_id_a;
      r_exmem_valid <= r_idex_valid;
      r_exmem_rd    <= r_idex_instr[11:7];
      r_exmem_data  <= w_ex_res;
      r_memwb_valid <= r_exmem_valid;
      r_memwb_rd    <= r_exmem_rd;
      r_memwb_data  <= r_exmem_data;
      r_mismatch    <= r_mismatch | w_diff;
      if (r_memwb_valid) r_count <= r_count + 32'd1;
    end
  end

  // WB write; in-flight work is dropped by the async clear of the valid bits.
  always_ff @(posedge clk) begin
    if (reset_n && r_memwb_valid && (r_memwb_rd != 5'd0)) core_rf[AW'(r_memwb_rd)] <= r_memwb_data;
  end

  assign commit_valid = r_memwb_valid;
  assign commit_rd    = r_memwb_rd;
  assign commit_data  = r_memwb_data;
  assign mismatch     = r_mismatch;
  assign commit_count = r_count;

endmodule

// File: tb/tb_sodor5_pipe_checker.sv
// Directed bench for sodor5_pipe_checker: reset values, single ADDI latency,
// dependent chains with 0..3 NOP gaps, x0 writes, shifts/compares,
// unsupported encodings, and a random ADDI loop with mid-stream reset.
module tb_sodor5_pipe_checker;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BUB = 32'h00000000;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        mismatch;
  logic [31:0] commit_count;

  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_count;

  sodor5_pipe_checker #(.NUM_REGS(32), .XLEN(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (instr),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .mismatch     (mismatch),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] sext(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  // Drive one word, advance one edge, leave time at edge+1.
  task automatic tick(input logic [31:0] ins);
    instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    tick(ins);
    exp_count = exp_count + 32'd1;
  endtask

  task automatic drain();
    repeat (5) tick(BUB);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    instr   = BUB;
    exp_count = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (commit_valid !== 1'b0) begin $display("FAIL reset_valid got=%0h want=0", commit_valid); n_bad++; end
    n_cmp++; if (commit_rd !== 5'd0) begin $display("FAIL reset_rd got=%0h want=0", commit_rd); n_bad++; end
    n_cmp++; if (commit_data !== 32'd0) begin $display("FAIL reset_data got=%0h want=0", commit_data); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL reset_mismatch got=%0h want=0", mismatch); n_bad++; end
    n_cmp++; if (commit_count !== 32'd0) begin $display("FAIL reset_count got=%0h want=0", commit_count); n_bad++; end
    reset_n = 1'b1;
    for (int i = 1; i < 32; i++) issue(enc(3'b000, 5'(i), 5'd0, 12'h000));
    drain();
    n_cmp++; if (commit_count !== exp_count) begin $display("FAIL init_count got=%0h want=%0h", commit_count, exp_count); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL init_mismatch got=%0h want=0", mismatch); n_bad++; end
  endtask

  task automatic test_single_addi();
    issue(enc(3'b000, 5'd2, 5'd0, 12'h010));
    drain();
    issue(32'h00410093);
    tick(BUB);
    tick(BUB);
    n_cmp++; if (commit_valid !== 1'b0) begin $display("FAIL addi_early got=%0h want=0", commit_valid); n_bad++; end
    tick(BUB);
    n_cmp++; if (commit_valid !== 1'b1) begin $display("FAIL addi_valid got=%0h want=1", commit_valid); n_bad++; end
    n_cmp++; if (commit_rd !== 5'd1) begin $display("FAIL addi_rd got=%0h want=1", commit_rd); n_bad++; end
    n_cmp++; if (commit_data !== 32'h14) begin $display("FAIL addi_data got=%0h want=14", commit_data); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL addi_mismatch got=%0h want=0", mismatch); n_bad++; end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int gap = 0; gap < 4; gap++) begin
      logic [31:0] q[$];
      logic [31:0] got[3];
      int          at[3];
      int          k;
      logic [31:0] want[3];
      want[0] = 32'h149; want[1] = 32'h3B6; want[2] = 32'h3B5;
      k = 0;
      for (int j = 0; j < 3; j++) begin got[j] = '0; at[j] = 0; end
      q.push_back(32'h14900093);
      for (int j = 0; j < gap; j++) q.push_back(NOP);
      q.push_back(32'h26D08113);
      for (int j = 0; j < gap; j++) q.push_back(NOP);
      q.push_back(32'hFFF10193);
      for (int j = 0; j < 5; j++) q.push_back(BUB);
      exp_count = exp_count + 32'(3 + 2 * gap);
      for (int c = 0; c < q.size(); c++) begin
        tick(q[c]);
        if (commit_valid && (commit_rd != 5'd0)) begin
          if (k < 3) begin got[k] = commit_data; at[k] = c; end
          k++;
        end
      end
      n_cmp++; if (k != 3) begin $display("FAIL chain%0d_ncommits got=%0d want=3", gap, k); n_bad++; end
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (got[j] !== want[j]) begin $display("FAIL chain%0d_data%0d got=%0h want=%0h", gap, j, got[j], want[j]); n_bad++; end
      end
      for (int j = 1; j < 3; j++) begin
        n_cmp++; if (at[j] - at[j-1] != gap + 1) begin $display("FAIL chain%0d_spacing%0d got=%0d want=%0d", gap, j, at[j] - at[j-1], gap + 1); n_bad++; end
      end
    end
    n_cmp++; if (commit_count !== exp_count) begin $display("FAIL chain_count got=%0h want=%0h", commit_count, exp_count); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL chain_mismatch got=%0h want=0", mismatch); n_bad++; end
  endtask

  task automatic test_x0();
    issue(32'h27700013);
    issue(enc(3'b000, 5'd1, 5'd0, 12'h005));
    tick(BUB);
    tick(BUB);
    n_cmp++; if (commit_valid !== 1'b1) begin $display("FAIL x0_valid got=%0h want=1", commit_valid); n_bad++; end
    n_cmp++; if (commit_rd !== 5'd0) begin $display("FAIL x0_rd got=%0h want=0", commit_rd); n_bad++; end
    n_cmp++; if (commit_data !== 32'h277) begin $display("FAIL x0_data got=%0h want=277", commit_data); n_bad++; end
    tick(BUB);
    n_cmp++; if (commit_rd !== 5'd1) begin $display("FAIL x0_next_rd got=%0h want=1", commit_rd); n_bad++; end
    n_cmp++; if (commit_data !== 32'h5) begin $display("FAIL x0_next_data got=%0h want=5", commit_data); n_bad++; end
    drain();
    n_cmp++; if (dut.core_rf[0] !== 32'h0) begin $display("FAIL x0_core_rf0 got=%0h want=0", dut.core_rf[0]); n_bad++; end
    n_cmp++; if (dut.core_rf[1] !== 32'h5) begin $display("FAIL x0_core_rf1 got=%0h want=5", dut.core_rf[1]); n_bad++; end
  endtask

  task automatic test_shift_cmp();
    logic [31:0] prog[6];
    logic [4:0]  e_rd[6];
    logic [31:0] e_data[6];
    logic [4:0]  g_rd[6];
    logic [31:0] g_data[6];
    int          k;
    prog[0] = enc(3'b000, 5'd5, 5'd0, 12'h001); e_rd[0] = 5'd5; e_data[0] = 32'h00000001;
    prog[1] = enc(3'b001, 5'd5, 5'd5, 12'h01F); e_rd[1] = 5'd5; e_data[1] = 32'h80000000;
    prog[2] = enc(3'b101, 5'd6, 5'd5, 12'h404); e_rd[2] = 5'd6; e_data[2] = 32'hF8000000;
    prog[3] = enc(3'b101, 5'd7, 5'd5, 12'h004); e_rd[3] = 5'd7; e_data[3] = 32'h08000000;
    prog[4] = enc(3'b010, 5'd8, 5'd5, 12'h000); e_rd[4] = 5'd8; e_data[4] = 32'h00000001;
    prog[5] = enc(3'b011, 5'd9, 5'd5, 12'h000); e_rd[5] = 5'd9; e_data[5] = 32'h00000000;
    k = 0;
    for (int j = 0; j < 6; j++) begin g_rd[j] = '0; g_data[j] = '0; end
    for (int c = 0; c < 11; c++) begin
      if (c < 6) issue(prog[c]);
      else       tick(BUB);
      if (commit_valid) begin
        if (k < 6) begin g_rd[k] = commit_rd; g_data[k] = commit_data; end
        k++;
      end
    end
    n_cmp++; if (k != 6) begin $display("FAIL shcmp_ncommits got=%0d want=6", k); n_bad++; end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (g_rd[j] !== e_rd[j]) begin $display("FAIL shcmp_rd%0d got=%0h want=%0h", j, g_rd[j], e_rd[j]); n_bad++; end
      n_cmp++; if (g_data[j] !== e_data[j]) begin $display("FAIL shcmp_data%0d got=%0h want=%0h", j, g_data[j], e_data[j]); n_bad++; end
    end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL shcmp_mismatch got=%0h want=0", mismatch); n_bad++; end
  endtask

  task automatic test_unsupported();
    logic [31:0] words[3];
    int          seen;
    words[0] = 32'h00000033;
    words[1] = 32'h00000000;
    words[2] = enc(3'b001, 5'd10, 5'd5, 12'h404);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick((c < 3) ? words[c] : BUB);
      if (commit_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin $display("FAIL unsup_commits got=%0d want=0", seen); n_bad++; end
    n_cmp++; if (commit_count !== exp_count) begin $display("FAIL unsup_count got=%0h want=%0h", commit_count, exp_count); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL unsup_mismatch got=%0h want=0", mismatch); n_bad++; end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] tb_rf[32];
    logic [31:0] loop_w[16];
    logic [31:0] prog[131];
    logic [4:0]  e_rd[131];
    logic [31:0] e_data[131];
    int          idx;
    int          bad_core;
    int          bad_model;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] imm;
    tb_rf[0] = '0;
    for (int i = 1; i < 32; i++) begin
      imm = 12'($urandom_range(0, 4095));
      prog[i-1] = enc(3'b000, 5'(i), 5'd0, imm);
      tb_rf[i] = sext(imm);
      e_rd[i-1] = 5'(i); e_data[i-1] = tb_rf[i];
    end
    for (int j = 0; j < 16; j++) begin
      rd  = 5'($urandom_range(1, 31));
      rs1 = 5'($urandom_range(0, 31));
      imm = 12'($urandom_range(0, 4095));
      loop_w[j] = enc(3'b000, rd, rs1, imm);
    end
    for (int c = 31; c < 131; c++) begin
      prog[c] = loop_w[(c - 31) % 16];
      rd  = prog[c][11:7];
      rs1 = prog[c][19:15];
      imm = prog[c][31:20];
      e_data[c] = ((rs1 == 5'd0) ? 32'd0 : tb_rf[rs1]) + sext(imm);
      e_rd[c] = rd;
      tb_rf[rd] = e_data[c];
    end
    idx = 0;
    for (int c = 0; c < 131; c++) begin
      issue(prog[c]);
      if (commit_valid) begin
        if (idx < 131) begin
          n_cmp++; if ((commit_rd !== e_rd[idx]) || (commit_data !== e_data[idx])) begin
            $display("FAIL loop_commit%0d got=%0h:%0h want=%0h:%0h", idx, commit_rd, commit_data, e_rd[idx], e_data[idx]); n_bad++; end
        end
        idx++;
      end
    end
    n_cmp++; if (idx != 128) begin $display("FAIL loop_ncommits got=%0d want=128", idx); n_bad++; end
    n_cmp++; if (commit_count !== exp_count - 32'd4) begin $display("FAIL loop_count got=%0h want=%0h", commit_count, exp_count - 32'd4); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL loop_mismatch got=%0h want=0", mismatch); n_bad++; end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (commit_valid !== 1'b0) begin $display("FAIL midrst_valid got=%0h want=0", commit_valid); n_bad++; end
    n_cmp++; if (commit_rd !== 5'd0) begin $display("FAIL midrst_rd got=%0h want=0", commit_rd); n_bad++; end
    n_cmp++; if (commit_data !== 32'd0) begin $display("FAIL midrst_data got=%0h want=0", commit_data); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL midrst_mismatch got=%0h want=0", mismatch); n_bad++; end
    n_cmp++; if (commit_count !== 32'd0) begin $display("FAIL midrst_count got=%0h want=0", commit_count); n_bad++; end
    tick(loop_w[0]);
    tick(loop_w[1]);
    reset_n   = 1'b1;
    exp_count = '0;
    issue(NOP);
    for (int e = 2; e <= 4; e++) begin
      n_cmp++; if (commit_valid !== 1'b0) begin $display("FAIL post_rst_quiet%0d got=%0h want=0", e - 1, commit_valid); n_bad++; end
      tick(BUB);
    end
    n_cmp++; if ((commit_valid !== 1'b1) || (commit_rd !== 5'd0)) begin
      $display("FAIL post_rst_first got=%0h:%0h want=1:0", commit_valid, commit_rd); n_bad++; end
    for (int i = 1; i < 32; i++) begin
      imm = 12'($urandom_range(0, 4095));
      issue(enc(3'b000, 5'(i), 5'd0, imm));
      tb_rf[i] = sext(imm);
    end
    drain();
    bad_core  = 0;
    bad_model = 0;
    for (int i = 1; i < 32; i++) begin
      if (dut.core_rf[i] !== tb_rf[i]) bad_core++;
      if (dut.model_rf[i] !== tb_rf[i]) bad_model++;
    end
    n_cmp++; if (bad_core != 0) begin $display("FAIL final_core_rf got=%0d bad regs want=0", bad_core); n_bad++; end
    n_cmp++; if (bad_model != 0) begin $display("FAIL final_model_rf got=%0d bad regs want=0", bad_model); n_bad++; end
    n_cmp++; if (commit_count !== exp_count) begin $display("FAIL final_count got=%0h want=%0h", commit_count, exp_count); n_bad++; end
    n_cmp++; if (mismatch !== 1'b0) begin $display("FAIL final_mismatch got=%0h want=0", mismatch); n_bad++; end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_count = '0;
    reset_n   = 1'b0;
    instr     = BUB;
    test_reset();
    test_single_addi();
    test_back_to_back();
    test_x0();
    test_shift_cmp();
    test_unsupported();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
